// File: rtl/sa_ram_pkg.sv
// Shared geometry and timing constants for the 128x6 scratch RAM and its read controller.
package sa_ram_pkg;

  localparam int SA_RAM_AW     = 7;
  localparam int SA_RAM_DW     = 6;
  localparam int SA_RAM_RD_LAT = 2;
  localparam int SA_RD_DEPTH   = 4;
  localparam int SA_RD_CNT_W   = 4;

  // Pointer advance that wraps at an arbitrary depth, so non-power-of-two FIFOs work.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sa_rd_skid_fifo.sv
// Response skid FIFO: registered storage, wrapping pointers and a separate occupancy count.
module sa_rd_skid_fifo
  import sa_ram_pkg::*;
#(
  parameter int DEPTH = SA_RD_DEPTH,
  parameter int DW    = SA_RAM_DW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output logic [DW-1:0]          pop_data,
  output logic [SA_RD_CNT_W-1:0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = SA_RD_CNT_W;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [DW-1:0] last_data;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & ~full;
  // When empty, present the most recently popped word rather than stale storage.
  assign pop_data = empty ? last_data : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_data <= '0;
    end else begin
      if (do_push) wr_ptr <= PW'(wrap_inc(32'(wr_ptr), DEPTH));
      if (do_pop) begin
        rd_ptr    <= PW'(wrap_inc(32'(rd_ptr), DEPTH));
        last_data <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  push_into_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full))
    else $fatal(1, "sa_rd_skid_fifo: push into full fifo");

endmodule

// File: rtl/sa_ram_rd_ctrl_128x6.sv
// Read-side controller for the 128x6 scratch RAM: credit-limited requests, fixed 2-stage RAM
// pipeline, and a skid FIFO so response backpressure never stalls the RAM.
module sa_ram_rd_ctrl_128x6
  import sa_ram_pkg::*;
#(
  parameter int AW    = SA_RAM_AW,
  parameter int DW    = SA_RAM_DW,
  parameter int DEPTH = SA_RD_DEPTH
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic                   rd_req_pvld,
  output logic                   rd_req_prdy,
  input  logic [AW-1:0]          rd_req_addr,
  output logic                   rd_rsp_pvld,
  input  logic                   rd_rsp_prdy,
  output logic [DW-1:0]          rd_rsp_data,
  output logic [AW-1:0]          ram_ra,
  output logic                   ram_re,
  output logic                   ram_ore,
  input  logic [DW-1:0]          ram_dout,
  output logic [SA_RD_CNT_W-1:0] rd_outstanding
);

  localparam int CW  = SA_RD_CNT_W;
  localparam int LAT = SA_RAM_RD_LAT;

  if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
    $error("sa_ram_rd_ctrl_128x6: DEPTH must be in 2..8");
  end

  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  fifo_count;
  logic [CW-1:0]  inflight_sum;
  logic [LAT-1:0] stage_vld;
  logic           accept;
  logic           pop;
  logic           push;
  logic           fifo_full;
  logic           fifo_empty;

  // Handshake: a transfer happens in any cycle where pvld && prdy at the rising edge.
  // prdy depends only on registered state; pvld may not be withdrawn based on prdy.
  assign rd_req_prdy    = (outstanding < CW'(DEPTH));
  assign accept         = nvdla_core_rstn & rd_req_pvld & rd_req_prdy;
  assign ram_re         = accept;
  assign ram_ra         = rd_req_addr;
  assign ram_ore        = stage_vld[0];
  assign push           = stage_vld[LAT-1];
  assign rd_rsp_pvld    = ~fifo_empty;
  assign pop            = rd_rsp_pvld & rd_rsp_prdy;
  assign rd_outstanding = outstanding;

  // stage_vld[0] tracks the RAM address register, stage_vld[LAT-1] its output register.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) stage_vld <= '0;
    else                  stage_vld <= {stage_vld[LAT-2:0], accept};
  end

  // A credit is taken on accept and returned only when the response leaves the FIFO.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_comb begin
    inflight_sum = fifo_count;
    for (int i = 0; i < LAT; i++) inflight_sum = inflight_sum + CW'(stage_vld[i]);
  end

  sa_rd_skid_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk       (nvdla_core_clk),
    .rst_n     (nvdla_core_rstn),
    .push      (push),
    .push_data (ram_dout),
    .pop       (pop),
    .pop_data  (rd_rsp_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  credit_matches_inflight: assert property (
    @(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn) outstanding == inflight_sum)
    else $error("sa_ram_rd_ctrl_128x6: credit count diverged from in-flight reads");

  full_means_no_credit: assert property (
    @(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn) fifo_full |-> (outstanding == CW'(DEPTH)))
    else $error("sa_ram_rd_ctrl_128x6: fifo full while credits remain");

endmodule

// File: tb/tb_sa_ram_rd_ctrl_128x6.sv
// Bench for sa_ram_rd_ctrl_128x6 with a behavioural 128x6 two-stage RAM and a response scoreboard.
module tb_sa_ram_rd_ctrl_128x6;

  localparam int AW = 7;
  localparam int DW = 6;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rd_req_pvld = 1'b0;
  logic          rd_req_prdy;
  logic [AW-1:0] rd_req_addr = '0;
  logic          rd_rsp_pvld;
  logic          rd_rsp_prdy = 1'b0;
  logic [DW-1:0] rd_rsp_data;
  logic [AW-1:0] ram_ra;
  logic          ram_re;
  logic          ram_ore;
  logic [DW-1:0] ram_dout;
  logic [3:0]    rd_outstanding;

  sa_ram_rd_ctrl_128x6 dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rst_n),
    .rd_req_pvld     (rd_req_pvld),
    .rd_req_prdy     (rd_req_prdy),
    .rd_req_addr     (rd_req_addr),
    .rd_rsp_pvld     (rd_rsp_pvld),
    .rd_rsp_prdy     (rd_rsp_prdy),
    .rd_rsp_data     (rd_rsp_data),
    .ram_ra          (ram_ra),
    .ram_re          (ram_re),
    .ram_ore         (ram_ore),
    .ram_dout        (ram_dout),
    .rd_outstanding  (rd_outstanding)
  );

  // RAM model: address register on ram_re, output register on ram_ore, write port for RAW test
  logic [DW-1:0] ram [128];
  logic [AW-1:0] ra_q     = '0;
  logic [DW-1:0] dout_q   = '0;
  logic          wr_en    = 1'b0;
  logic [AW-1:0] wr_addr  = '0;
  logic [DW-1:0] wr_data  = '0;
  assign ram_dout = dout_q;
  always @(posedge clk) begin
    if (wr_en)   ram[wr_addr] <= wr_data;
    if (ram_re)  ra_q         <= ram_ra;
    if (ram_ore) dout_q       <= ram[ra_q];
  end

  // scoreboard
  logic [DW-1:0] exp_q[$];
  int            pop_cyc_q[$];
  int            checks  = 0;
  int            errors  = 0;
  int            max_out = 0;
  logic [DW-1:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (32'(rd_outstanding) > max_out) max_out = 32'(rd_outstanding);
      if (rd_rsp_pvld && rd_rsp_prdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'(rd_rsp_data), 32'hFFFF_FFFF);
        end else begin
          mon_exp = exp_q.pop_front();
          check("rsp_data", 32'(rd_rsp_data), 32'(mon_exp));
        end
        pop_cyc_q.push_back(cyc);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] e, output int acc_cyc);
    int n;
    n = 0;
    acc_cyc = -1;
    rd_req_pvld = 1'b1;
    rd_req_addr = a;
    @(negedge clk);
    while (!rd_req_prdy && n < 40) begin
      n++;
      tick();
      @(negedge clk);
    end
    if (rd_req_prdy) begin
      exp_q.push_back(e);
      acc_cyc = cyc;
    end else begin
      check("req_accept_timeout", 32'(rd_req_prdy), 32'd1);
    end
    tick();
    rd_req_pvld = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rd_outstanding != 0) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) check({name, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
  endtask

  logic [DW-1:0] burst_tab [16] = '{6'h03, 6'h08, 6'h0D, 6'h12, 6'h17, 6'h2A, 6'h21, 6'h26,
                                    6'h2B, 6'h30, 6'h35, 6'h3A, 6'h3F, 6'h04, 6'h09, 6'h0E};
  logic [DW-1:0] bp_tab [6] = '{6'h23, 6'h28, 6'h2D, 6'h32, 6'h37, 6'h3C};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c, bad, acc, first_block;
    for (int i = 0; i < 128; i++) ram[i] = 6'((i * 5 + 3) % 64);
    ram[5] = 6'h2A;

    // reset state
    #1;
    check("rst_prdy", 32'(rd_req_prdy), 32'd1);
    check("rst_rsp_pvld", 32'(rd_rsp_pvld), 32'd0);
    check("rst_rsp_data", 32'(rd_rsp_data), 32'd0);
    check("rst_ore", 32'(ram_ore), 32'd0);
    check("rst_outstanding", 32'(rd_outstanding), 32'd0);
    rd_req_pvld = 1'b1;
    rd_req_addr = 7'h12;
    #1;
    check("rst_re_gated", 32'(ram_re), 32'd0);
    check("rst_ra_pass", 32'(ram_ra), 32'h12);
    rd_req_pvld = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // single read with timing
    rd_rsp_prdy = 1'b1;
    rd_req_pvld = 1'b1;
    rd_req_addr = 7'h05;
    @(negedge clk);
    check("single_re", 32'(ram_re), 32'd1);
    check("single_ra", 32'(ram_ra), 32'h05);
    exp_q.push_back(6'h2A);
    c0 = cyc;
    tick();
    rd_req_pvld = 1'b0;
    @(negedge clk);
    check("single_ore_c1", 32'(ram_ore), 32'd1);
    check("single_re_c1", 32'(ram_re), 32'd0);
    check("single_pvld_c1", 32'(rd_rsp_pvld), 32'd0);
    tick();
    @(negedge clk);
    check("single_ore_c2", 32'(ram_ore), 32'd0);
    check("single_pvld_c2", 32'(rd_rsp_pvld), 32'd0);
    check("single_out_c2", 32'(rd_outstanding), 32'd1);
    tick();
    @(negedge clk);
    check("single_pvld_c3", 32'(rd_rsp_pvld), 32'd1);
    check("single_latency", 32'(cyc - c0), 32'd3);
    tick();
    @(negedge clk);
    check("single_pvld_c4", 32'(rd_rsp_pvld), 32'd0);
    check("single_data_hold", 32'(rd_rsp_data), 32'h2A);
    check("single_out_c4", 32'(rd_outstanding), 32'd0);
    tick();

    // burst of 16 with rd_rsp_prdy held high
    pop_cyc_q.delete();
    max_out = 0;
    bad = 0;
    c0 = 0;
    for (int i = 0; i < 16; i++) begin
      issue(7'(i), burst_tab[i], c);
      if (i == 0) c0 = c;
      else if (c != c0 + i) bad++;
    end
    wait_idle("burst");
    check("burst_prdy_stalls", 32'(bad), 32'd0);
    check("burst_max_outstanding", 32'(max_out), 32'd3);
    check("burst_rsp_count", 32'(pop_cyc_q.size()), 32'd16);
    bad = 0;
    for (int i = 0; i < pop_cyc_q.size(); i++) if (pop_cyc_q[i] != c0 + 3 + i) bad++;
    check("burst_rsp_cycles", 32'(bad), 32'd0);

    // backpressure: credits run out at DEPTH
    rd_rsp_prdy = 1'b0;
    acc = 0;
    first_block = -1;
    rd_req_pvld = 1'b1;
    rd_req_addr = 7'h20;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rd_req_prdy) begin
        exp_q.push_back(bp_tab[acc]);
        acc++;
      end else if (first_block < 0) begin
        first_block = k;
      end
      tick();
      rd_req_addr = 7'(32'h20 + acc);
    end
    check("bp_accepted", 32'(acc), 32'd4);
    check("bp_first_block", 32'(first_block), 32'd4);
    check("bp_outstanding", 32'(rd_outstanding), 32'd4);
    check("bp_rsp_pvld", 32'(rd_rsp_pvld), 32'd1);
    check("bp_head", 32'(rd_rsp_data), 32'h23);
    rd_rsp_prdy = 1'b1;
    @(negedge clk);
    check("bp_prdy_at_pop", 32'(rd_req_prdy), 32'd0);
    tick();
    @(negedge clk);
    check("bp_prdy_after_pop", 32'(rd_req_prdy), 32'd1);
    if (rd_req_prdy) exp_q.push_back(bp_tab[4]);
    tick();
    rd_req_addr = 7'h25;
    @(negedge clk);
    check("bp_prdy_resume", 32'(rd_req_prdy), 32'd1);
    if (rd_req_prdy) exp_q.push_back(bp_tab[5]);
    tick();
    rd_req_pvld = 1'b0;
    wait_idle("backpressure");

    // simultaneous accept and pop at outstanding 3
    rd_rsp_prdy = 1'b0;
    issue(7'h50, 6'h13, c);
    issue(7'h51, 6'h18, c);
    issue(7'h52, 6'h1D, c);
    tick();
    tick();
    rd_rsp_prdy = 1'b1;
    rd_req_pvld = 1'b1;
    rd_req_addr = 7'h53;
    @(negedge clk);
    check("simul_out_before", 32'(rd_outstanding), 32'd3);
    check("simul_prdy", 32'(rd_req_prdy), 32'd1);
    check("simul_rsp_pvld", 32'(rd_rsp_pvld), 32'd1);
    if (rd_req_prdy) exp_q.push_back(6'h22);
    tick();
    rd_req_pvld = 1'b0;
    @(negedge clk);
    check("simul_out_after", 32'(rd_outstanding), 32'd3);
    tick();
    wait_idle("simul");

    // read during a same-cycle, same-address write
    wr_en   = 1'b1;
    wr_addr = 7'h7F;
    wr_data = 6'h11;
    issue(7'h7F, 6'h11, c);
    wr_en = 1'b0;
    wait_idle("raw");

    // asynchronous reset with three reads in flight
    rd_rsp_prdy = 1'b0;
    issue(7'h60, 6'h23, c);
    issue(7'h61, 6'h28, c);
    issue(7'h62, 6'h2D, c);
    check("mid_out_before_rst", 32'(rd_outstanding), 32'd3);
    rd_req_pvld = 1'b1;
    rd_req_addr = 7'h61;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_rsp_pvld", 32'(rd_rsp_pvld), 32'd0);
    check("mid_rst_outstanding", 32'(rd_outstanding), 32'd0);
    check("mid_rst_ore", 32'(ram_ore), 32'd0);
    check("mid_rst_re", 32'(ram_re), 32'd0);
    check("mid_rst_data", 32'(rd_rsp_data), 32'd0);
    check("mid_rst_prdy", 32'(rd_req_prdy), 32'd1);
    rd_req_pvld = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd_rsp_prdy = 1'b1;
    tick();
    pop_cyc_q.delete();
    issue(7'h3C, 6'h2F, c);
    wait_idle("post_rst");
    check("post_rst_rsp_count", 32'(pop_cyc_q.size()), 32'd1);
    if (pop_cyc_q.size() > 0) check("post_rst_latency", 32'(pop_cyc_q[0] - c), 32'd3);

    tick();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
